// File: rtl/cpu_pkg.sv
// Shared pipeline definitions for the 5-stage MIPS core.
//   STG_*             : index of each pipeline register in pause/bubble vectors
//   PIPE_DEPTH        : number of pipeline registers (PC, if_id, id_ex, ex_mem, mem_wb)
//   pipe_ctrl_state_t : redirect sequencer states
package cpu_pkg;

    localparam int STG_PC     = 0;
    localparam int STG_IF     = 1;
    localparam int STG_ID     = 2;
    localparam int STG_EX     = 3;
    localparam int STG_MEM    = 4;
    localparam int PIPE_DEPTH = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } pipe_ctrl_state_t;

endpackage

// File: rtl/stall_decode.sv
// Combinational stall decode.
//   stallreq : per-stage stall requests {mem,ex,id,if}, bit0 = IF
//   pause    : hold enable per pipeline register, bit0 = PC
//   bubble   : load-NOP enable per pipeline register, bit0 = PC
// The highest requesting stage s (IF=1 .. MEM=4) holds every register
// upstream of it and injects a bubble into register s.
module stall_decode
    import cpu_pkg::*;
(
    input  logic [PIPE_DEPTH-2:0] stallreq,
    output logic [PIPE_DEPTH-1:0] pause,
    output logic [PIPE_DEPTH-1:0] bubble
);

    always_comb begin
        pause  = '0;
        bubble = '0;
        // Ascending scan: the highest set request overwrites lower ones.
        for (int i = 0; i < PIPE_DEPTH - 1; i++) begin
            if (stallreq[i]) begin
                pause  = PIPE_DEPTH'((1 << (i + 1)) - 1);
                bubble = PIPE_DEPTH'(1 << (i + 1));
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
//   clock        : system clock
//   reset        : synchronous, active-low
//   ready        : global bus ready, 0 freezes every pipeline register
//   stallreq     : stall requests {mem,ex,id,if}
//   exc_req      : redirect request (exception / ERET) from MEM, level
//   exc_target   : redirect PC, valid with exc_req
//   cnt_clear    : synchronous clear of stall_cnt
//   pause        : hold enables, bit0 PC .. bit4 mem_wb
//   bubble       : load-NOP enables, same order
//   flush        : flush all pipeline registers, PC := flush_target
//   flush_target : redirect PC
//   busy         : redirect pending or in progress
//   stall_cnt    : saturating count of ready cycles with any pause bit set
//
// state | meaning
// RUN   | normal operation; redirect issued immediately when ready
// PEND  | redirect latched while bus frozen, waiting for ready
// FLUSH | flush held for the remaining ready cycles of the redirect
module pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ready,
    input  logic [3:0]            stallreq,
    input  logic                  exc_req,
    input  logic [31:0]           exc_target,
    input  logic                  cnt_clear,
    output logic [4:0]            pause,
    output logic [4:0]            bubble,
    output logic                  flush,
    output logic [31:0]           flush_target,
    output logic                  busy,
    output logic [CNT_W-1:0]      stall_cnt
);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_cfg
        $error("pipe_ctrl: FLUSH_CYCLES must be in 1..15");
    end

    // Ready cycles still owed after the issuing cycle.
    localparam logic [3:0] FLUSH_LEFT = 4'(FLUSH_CYCLES - 1);
    localparam bit         MULTI      = (FLUSH_CYCLES > 1);

    pipe_ctrl_state_t state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [31:0]      target_q, target_d;
    logic [4:0]       dec_pause, dec_bubble;

    stall_decode u_stall_decode (
        .stallreq (stallreq),
        .pause    (dec_pause),
        .bubble   (dec_bubble)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        target_d     = target_q;
        flush        = 1'b0;
        flush_target = target_q;
        case (state_q)
            RUN: begin
                if (exc_req) begin
                    target_d     = exc_target;
                    flush_target = exc_target;
                    if (ready) begin
                        flush = 1'b1;
                        if (MULTI) begin
                            state_d = FLUSH;
                            cnt_d   = FLUSH_LEFT;
                        end
                    end else begin
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                if (ready) begin
                    flush = 1'b1;
                    if (MULTI) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_LEFT;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (ready) begin
                    if (cnt_q <= 4'd1) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    // A redirect squashes everything, so stall outputs are meaningless then.
    assign pause  = flush ? '0 : dec_pause;
    assign bubble = flush ? '0 : dec_bubble;
    assign busy   = (state_q != RUN);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            target_q  <= '0;
            stall_cnt <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            if (cnt_clear) begin
                stall_cnt <= '0;
            end else if (ready && !flush && (|pause) && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    logic        clock;
    logic        reset;
    logic        ready;
    logic [3:0]  stallreq;
    logic        exc_req;
    logic [31:0] exc_target;
    logic        cnt_clear;

    logic [4:0]  p1, b1, p3, b3;
    logic        f1, f3, y1, y3;
    logic [31:0] t1, t3;
    logic [3:0]  c1;
    logic [31:0] c3;

    int n_checks = 0;
    int n_fail   = 0;

    // Single-cycle flush, narrow counter for saturation.
    pipe_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) dut1 (
        .clock(clock), .reset(reset), .ready(ready), .stallreq(stallreq),
        .exc_req(exc_req), .exc_target(exc_target), .cnt_clear(cnt_clear),
        .pause(p1), .bubble(b1), .flush(f1), .flush_target(t1),
        .busy(y1), .stall_cnt(c1)
    );

    // Three-cycle flush, full-width counter.
    pipe_ctrl #(.FLUSH_CYCLES(3), .CNT_W(32)) dut3 (
        .clock(clock), .reset(reset), .ready(ready), .stallreq(stallreq),
        .exc_req(exc_req), .exc_target(exc_target), .cnt_clear(cnt_clear),
        .pause(p3), .bubble(b3), .flush(f3), .flush_target(t3),
        .busy(y3), .stall_cnt(c3)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Inputs change 1 time unit after a rising edge; outputs are sampled
    // mid-cycle (#4 later, at the falling edge).
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ready      = 1'b1;
        stallreq   = 4'b0000;
        exc_req    = 1'b0;
        exc_target = 32'h0;
        cnt_clear  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        #4;
        n_checks++;
        if ({p1, b1, f1, y1} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_outs1 got %b exp 0", {p1, b1, f1, y1});
        end
        n_checks++;
        if (t1 !== 32'h0 || c1 !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_tgt_cnt1 got %h/%0d exp 0/0", t1, c1);
        end
        n_checks++;
        if ({p3, b3, f3, y3} !== 12'h0 || t3 !== 32'h0 || c3 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outs3 got %b %h %0d exp 0", {p3, b3, f3, y3}, t3, c3);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_stall_decode();
        logic [3:0] req [6]  = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1010, 4'b0111};
        logic [4:0] ep  [6]  = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b00111};
        logic [4:0] eb  [6]  = '{5'b00000, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01000};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            stallreq = req[i];
            ready    = i[0];
            #4;
            n_checks++;
            if (p1 !== ep[i] || b1 !== eb[i]) begin
                n_fail++;
                $display("FAIL decode_%b got pause %b bubble %b exp %b %b",
                         req[i], p1, b1, ep[i], eb[i]);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_redirect_ready();
        do_reset();
        stallreq   = 4'b0100;
        exc_req    = 1'b1;
        exc_target = 32'h8000_0180;
        #4;
        n_checks++;
        if (f1 !== 1'b1 || t1 !== 32'h8000_0180) begin
            n_fail++;
            $display("FAIL redir_flush got %b %h exp 1 80000180", f1, t1);
        end
        n_checks++;
        if (p1 !== 5'b0 || b1 !== 5'b0) begin
            n_fail++;
            $display("FAIL redir_override got %b %b exp 0 0", p1, b1);
        end
        tick();
        exc_req  = 1'b0;
        stallreq = 4'b0000;
        #4;
        n_checks++;
        if (f1 !== 1'b0 || y1 !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_after got flush %b busy %b exp 0 0", f1, y1);
        end
        tick();
    endtask

    task automatic test_pending();
        do_reset();
        ready      = 1'b0;
        exc_req    = 1'b1;
        exc_target = 32'hBFC0_0380;
        #4;
        n_checks++;
        if (f1 !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_first got flush %b exp 0", f1);
        end
        tick();
        exc_target = 32'h8000_0000;
        for (int i = 0; i < 2; i++) begin
            #4;
            n_checks++;
            if (f1 !== 1'b0 || y1 !== 1'b1 || t1 !== 32'hBFC0_0380) begin
                n_fail++;
                $display("FAIL pend_hold%0d got flush %b busy %b tgt %h exp 0 1 bfc00380",
                         i, f1, y1, t1);
            end
            tick();
        end
        ready = 1'b1;
        #4;
        n_checks++;
        if (f1 !== 1'b1 || t1 !== 32'hBFC0_0380) begin
            n_fail++;
            $display("FAIL pend_issue got flush %b tgt %h exp 1 bfc00380", f1, t1);
        end
        tick();
        exc_req = 1'b0;
        #4;
        n_checks++;
        if (f1 !== 1'b0 || y1 !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_done got flush %b busy %b exp 0 0", f1, y1);
        end
        tick();
    endtask

    task automatic test_flush_multi();
        logic       rdy [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic       eby [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        stallreq   = 4'b0001;
        exc_target = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            exc_req = (i == 0);
            ready   = rdy[i];
            #4;
            n_checks++;
            if (f3 !== 1'b1 || t3 !== 32'h1234_5678 || y3 !== eby[i] || p3 !== 5'b0) begin
                n_fail++;
                $display("FAIL multi_cyc%0d got flush %b tgt %h busy %b pause %b exp 1 12345678 %b 0",
                         i, f3, t3, y3, p3, eby[i]);
            end
            tick();
        end
        #4;
        n_checks++;
        if (f3 !== 1'b0 || y3 !== 1'b0 || p3 !== 5'b00001 || c3 !== 32'd0) begin
            n_fail++;
            $display("FAIL multi_end got flush %b busy %b pause %b cnt %0d exp 0 0 00001 0",
                     f3, y3, p3, c3);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_counter();
        do_reset();
        stallreq = 4'b0001;
        for (int i = 0; i < 10; i++) tick();
        #4;
        n_checks++;
        if (c1 !== 4'd10 || c3 !== 32'd10) begin
            n_fail++;
            $display("FAIL cnt_ten got %0d/%0d exp 10/10", c1, c3);
        end
        ready = 1'b0;
        tick();
        tick();
        #4;
        n_checks++;
        if (c1 !== 4'd10 || c3 !== 32'd10) begin
            n_fail++;
            $display("FAIL cnt_frozen got %0d/%0d exp 10/10", c1, c3);
        end
        ready     = 1'b1;
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        #4;
        n_checks++;
        if (c1 !== 4'd0 || c3 !== 32'd0) begin
            n_fail++;
            $display("FAIL cnt_clear got %0d/%0d exp 0/0", c1, c3);
        end
        for (int i = 0; i < 20; i++) tick();
        #4;
        n_checks++;
        if (c1 !== 4'd15 || c3 !== 32'd20) begin
            n_fail++;
            $display("FAIL cnt_sat got %0d/%0d exp 15/20", c1, c3);
        end
        cnt_clear  = 1'b1;
        exc_req    = 1'b1;
        exc_target = 32'h8000_0180;
        #4;
        n_checks++;
        if (f1 !== 1'b1) begin
            n_fail++;
            $display("FAIL cnt_exc_flush got %b exp 1", f1);
        end
        tick();
        cnt_clear = 1'b0;
        exc_req   = 1'b0;
        #4;
        n_checks++;
        if (c1 !== 4'd0 || c3 !== 32'd0) begin
            n_fail++;
            $display("FAIL cnt_exc_clear got %0d/%0d exp 0/0", c1, c3);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid_pend();
        do_reset();
        stallreq = 4'b0001;
        for (int i = 0; i < 3; i++) tick();
        ready      = 1'b0;
        exc_req    = 1'b1;
        exc_target = 32'hBFC0_0380;
        tick();
        exc_req = 1'b0;
        #4;
        n_checks++;
        if (y1 !== 1'b1 || y3 !== 1'b1 || c1 !== 4'd3) begin
            n_fail++;
            $display("FAIL rstpend_pre got busy %b/%b cnt %0d exp 1/1 3", y1, y3, c1);
        end
        reset    = 1'b0;
        stallreq = 4'b0000;
        tick();
        #4;
        n_checks++;
        if (y1 !== 1'b0 || f1 !== 1'b0 || c1 !== 4'd0 || t1 !== 32'h0) begin
            n_fail++;
            $display("FAIL rstpend_in got busy %b flush %b cnt %0d tgt %h exp 0 0 0 0",
                     y1, f1, c1, t1);
        end
        n_checks++;
        if (y3 !== 1'b0 || f3 !== 1'b0 || c3 !== 32'd0) begin
            n_fail++;
            $display("FAIL rstpend_in3 got busy %b flush %b cnt %0d exp 0 0 0", y3, f3, c3);
        end
        reset = 1'b1;
        ready = 1'b1;
        tick();
        #4;
        n_checks++;
        if (f1 !== 1'b0 || f3 !== 1'b0) begin
            n_fail++;
            $display("FAIL rstpend_noflush got %b/%b exp 0/0", f1, f3);
        end
        tick();
        #4;
        n_checks++;
        if (f1 !== 1'b0 || y1 !== 1'b0 || y3 !== 1'b0) begin
            n_fail++;
            $display("FAIL rstpend_idle got flush %b busy %b/%b exp 0 0/0", f1, y1, y3);
        end
        tick();
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_stall_decode();
        test_redirect_ready();
        test_pending();
        test_flush_multi();
        test_counter();
        test_reset_mid_pend();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
